// File: rtl/reaction_arena_if.sv
// reaction_arena_if: button inputs and display/status outputs of the reaction game core.
interface reaction_arena_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int TIME_W      = 14
);
   localparam int PID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   logic                   start_btn;
   logic [NUM_PLAYERS-1:0] react_btn;
   logic                   led_go;
   logic [2:0]             state_out;
   logic                   result_valid;
   logic [PID_W-1:0]       winner_id;
   logic [TIME_W-1:0]      time_ms;
   logic [NUM_PLAYERS-1:0] error_mask;
   logic [TIME_W-1:0]      best_ms;
   modport master (
      output start_btn, react_btn,
      input  led_go, state_out, result_valid, winner_id, time_ms, error_mask, best_ms
   );
   modport slave (
      input  start_btn, react_btn,
      output led_go, state_out, result_valid, winner_id, time_ms, error_mask, best_ms
   );
endinterface

// File: rtl/reaction_arena.sv
// reaction_arena: multi-player reaction timer with LFSR delay, false-start detection,
// timeout and best-time tracking.
module reaction_arena #(
   parameter int          NUM_PLAYERS     = 2,
   parameter int          TICK_DIV        = 50000,
   parameter int          TIME_W          = 14,
   parameter int          MAX_MS          = 9999,
   parameter int          DELAY_MIN_MS    = 1000,
   parameter int          DELAY_SPAN_BITS = 11,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input logic          clk,
   input logic          reset,
   reaction_arena_if.slave bus
);
   localparam int PID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_GO      = 3'd2;
   localparam logic [2:0] S_RESULT  = 3'd3;
   localparam logic [2:0] S_FOUL    = 3'd4;
   localparam logic [2:0] S_TIMEOUT = 3'd5;

   logic                   r_start_q;
   logic [NUM_PLAYERS-1:0] r_react_q;
   logic [2:0]             r_state;
   logic                   r_led_go;
   logic                   r_result_valid;
   logic [PID_W-1:0]       r_winner;
   logic [TIME_W-1:0]      r_time;
   logic [NUM_PLAYERS-1:0] r_mask;
   logic [TIME_W-1:0]      r_best;
   logic [15:0]            r_lfsr;
   logic [PRE_W-1:0]       r_presc;
   logic [TIME_W-1:0]      r_delay;
   logic [TIME_W-1:0]      r_elapsed;

   logic                   w_start_rise;
   logic [NUM_PLAYERS-1:0] w_react_rise;
   logic                   w_tick;
   logic                   w_begin;
   logic [15:0]            w_lfsr_next;
   logic [2:0]             w_nxt;
   logic [PID_W-1:0]       w_win;

   assign w_start_rise = bus.start_btn & ~r_start_q;
   assign w_react_rise = bus.react_btn & ~r_react_q;
   assign w_tick       = r_presc == PRE_W'(TICK_DIV - 1);
   assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_begin      = w_start_rise && (r_state == S_IDLE || r_state == S_RESULT ||
                                          r_state == S_FOUL || r_state == S_TIMEOUT);

   // A false start outranks the GO transition that would happen on the same cycle.
   always_comb begin
      w_nxt = r_state;
      if (w_begin)
         w_nxt = S_ARMED;
      else if (r_state == S_ARMED)
         w_nxt = |w_react_rise ? S_FOUL : (w_tick && r_delay == TIME_W'(1)) ? S_GO : S_ARMED;
      else if (r_state == S_GO)
         w_nxt = |w_react_rise ? S_RESULT :
                 (w_tick && r_elapsed == TIME_W'(MAX_MS - 1)) ? S_TIMEOUT : S_GO;
   end

   always_comb begin
      w_win = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--)
         if (w_react_rise[i]) w_win = PID_W'(i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_start_q      <= 1'b0;
         r_react_q      <= '0;
         r_state        <= S_IDLE;
         r_led_go       <= 1'b0;
         r_result_valid <= 1'b0;
         r_winner       <= '0;
         r_time         <= '0;
         r_mask         <= '0;
         r_best         <= TIME_W'(MAX_MS);
         r_lfsr         <= LFSR_SEED;
         r_presc        <= '0;
         r_delay        <= '0;
         r_elapsed      <= '0;
      end else begin
         r_start_q      <= bus.start_btn;
         r_react_q      <= bus.react_btn;
         r_state        <= w_nxt;
         r_led_go       <= w_nxt == S_GO;
         r_result_valid <= w_nxt == S_RESULT;
         r_presc        <= (w_tick || (w_nxt != r_state && (w_nxt == S_ARMED || w_nxt == S_GO)))
                           ? '0 : r_presc + 1'b1;
         r_elapsed      <= (r_state != S_GO) ? '0 : w_tick ? r_elapsed + 1'b1 : r_elapsed;
         if (w_begin) begin
            r_lfsr  <= w_lfsr_next;
            r_delay <= TIME_W'(DELAY_MIN_MS) + TIME_W'(w_lfsr_next[DELAY_SPAN_BITS-1:0]);
            r_mask  <= '0;
         end
         if (r_state == S_ARMED && w_tick)
            r_delay <= r_delay - 1'b1;
         if (r_state == S_ARMED && w_nxt == S_FOUL)
            r_mask <= w_react_rise;
         if (r_state == S_GO && w_nxt == S_RESULT) begin
            r_winner <= w_win;
            r_time   <= r_elapsed;
            r_best   <= (r_elapsed < r_best) ? r_elapsed : r_best;
         end
         if (r_state == S_GO && w_nxt == S_TIMEOUT)
            r_time <= TIME_W'(MAX_MS);
      end
   end

   assign bus.led_go       = r_led_go;
   assign bus.state_out    = r_state;
   assign bus.result_valid = r_result_valid;
   assign bus.winner_id    = r_winner;
   assign bus.time_ms      = r_time;
   assign bus.error_mask   = r_mask;
   assign bus.best_ms      = r_best;
endmodule

// File: tb/tb_reaction_arena.sv
// tb_reaction_arena: scoreboard bench; round outcomes are queued when the deciding
// stimulus is driven and popped when the core enters RESULT, FOUL or TIMEOUT.
module tb_reaction_arena;
   localparam int TICK_DIV = 4;
   localparam int MAX_MS   = 20;

   typedef struct {
      logic [2:0]  st;
      logic        win;
      logic [13:0] t;
      logic [1:0]  mask;
      logic [13:0] best;
      logic        valid;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          go_cyc = 0;
   int          m_delay = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [1:0]  m_react = 2'b00;
   logic        m_win = 1'b0;
   logic [13:0] m_time = '0;
   logic [13:0] m_best = 14'(MAX_MS);
   logic [2:0]  prev_st;
   exp_t        sb_q[$];
   exp_t        e_cur;

   reaction_arena_if #(.NUM_PLAYERS(2), .TIME_W(14)) bus ();

   reaction_arena #(
      .NUM_PLAYERS(2), .TICK_DIV(TICK_DIV), .TIME_W(14), .MAX_MS(MAX_MS),
      .DELAY_MIN_MS(2), .DELAY_SPAN_BITS(2), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   always @(negedge clk) begin
      if (bus.state_out != prev_st && bus.state_out >= 3'd3) begin
         if (sb_q.size() == 0)
            check("sb_unexpected_end", int'(bus.state_out), 0);
         else begin
            e_cur = sb_q.pop_front();
            check("sb_state", int'(bus.state_out), int'(e_cur.st));
            check("sb_winner", int'(bus.winner_id), int'(e_cur.win));
            check("sb_time", int'(bus.time_ms), int'(e_cur.t));
            check("sb_mask", int'(bus.error_mask), int'(e_cur.mask));
            check("sb_best", int'(bus.best_ms), int'(e_cur.best));
            check("sb_valid", int'(bus.result_valid), int'(e_cur.valid));
            check("sb_led", int'(bus.led_go), 0);
         end
      end
      prev_st = bus.state_out;
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_round();
      bus.start_btn = 1'b1;
      step();
      bus.start_btn = 1'b0;
      m_lfsr  = lfsr_step(m_lfsr);
      m_delay = 2 + int'(m_lfsr[1:0]);
      check("armed", int'(bus.state_out), 1);
      check("lfsr", int'(dut.r_lfsr), int'(m_lfsr));
      check("mask_clear", int'(bus.error_mask), 0);
   endtask

   task automatic wait_go();
      int n = 0;
      while (!bus.led_go && n < 200) begin
         step();
         n++;
      end
      check("go_cycles", n, m_delay * TICK_DIV);
      check("go_state", int'(bus.state_out), 2);
      go_cyc = cyc;
   endtask

   task automatic press_at(input int n, input logic [1:0] val);
      logic [1:0] rise;
      exp_t e;
      while (cyc - go_cyc < n - 1) step();
      rise   = val & ~m_react;
      m_win  = rise[0] ? 1'b0 : 1'b1;
      m_time = 14'(n / TICK_DIV);
      if (m_time < m_best) m_best = m_time;
      e = '{st: 3'd3, win: m_win, t: m_time, mask: 2'b00, best: m_best, valid: 1'b1};
      sb_q.push_back(e);
      bus.react_btn = val;
      m_react = val;
      step();
   endtask

   task automatic foul(input logic [1:0] val);
      exp_t e;
      e = '{st: 3'd4, win: m_win, t: m_time, mask: val & ~m_react, best: m_best, valid: 1'b0};
      sb_q.push_back(e);
      bus.react_btn = val;
      m_react = val;
      step();
   endtask

   task automatic set_react(input logic [1:0] val);
      bus.react_btn = val;
      m_react = val;
      step();
   endtask

   initial begin
      int n;
      exp_t e;
      bus.start_btn = 1'b0;
      bus.react_btn = 2'b00;
      repeat (3) step();
      check("rst_state", int'(bus.state_out), 0);
      check("rst_led", int'(bus.led_go), 0);
      check("rst_valid", int'(bus.result_valid), 0);
      check("rst_winner", int'(bus.winner_id), 0);
      check("rst_time", int'(bus.time_ms), 0);
      check("rst_mask", int'(bus.error_mask), 0);
      check("rst_best", int'(bus.best_ms), MAX_MS);
      reset = 1'b0;
      step();

      // Round 1: player 1 reacts 10 cycles into GO.
      start_round();
      check("lfsr_first", int'(dut.r_lfsr), 'h59C3);
      check("delay_first", m_delay, 5);
      wait_go();
      press_at(10, 2'b10);
      check("r1_led", int'(bus.led_go), 0);
      set_react(2'b00);

      // Round 2: both players jump the gun.
      start_round();
      repeat (3) step();
      foul(2'b11);
      repeat (30) step();
      check("foul_hold", int'(bus.state_out), 4);
      check("foul_led", int'(bus.led_go), 0);
      set_react(2'b00);

      // Round 3: start ignored in GO, then a tie goes to player 0.
      start_round();
      wait_go();
      bus.start_btn = 1'b1;
      step();
      bus.start_btn = 1'b0;
      check("start_ign", int'(bus.state_out), 2);
      press_at(5, 2'b11);
      set_react(2'b01);

      // Round 4: player 0 held throughout, only player 1 produces a rise.
      start_round();
      wait_go();
      press_at(7, 2'b11);
      set_react(2'b00);

      // Round 5: nobody reacts.
      start_round();
      wait_go();
      m_time = 14'(MAX_MS);
      e = '{st: 3'd5, win: m_win, t: m_time, mask: 2'b00, best: m_best, valid: 1'b0};
      sb_q.push_back(e);
      n = 0;
      while (bus.state_out == 3'd2 && n < 200) begin
         step();
         n++;
      end
      check("timeout_cycles", n, MAX_MS * TICK_DIV);

      // Round 6: restart from TIMEOUT, then reset during GO.
      start_round();
      wait_go();
      repeat (3) step();
      reset = 1'b1;
      step();
      check("mid_rst_state", int'(bus.state_out), 0);
      check("mid_rst_led", int'(bus.led_go), 0);
      check("mid_rst_valid", int'(bus.result_valid), 0);
      check("mid_rst_winner", int'(bus.winner_id), 0);
      check("mid_rst_time", int'(bus.time_ms), 0);
      check("mid_rst_mask", int'(bus.error_mask), 0);
      check("mid_rst_best", int'(bus.best_ms), MAX_MS);
      reset = 1'b0;
      m_lfsr = 16'hACE1;
      m_best = 14'(MAX_MS);
      m_win  = 1'b0;
      m_time = '0;
      step();
      start_round();
      check("lfsr_restart", int'(dut.r_lfsr), 'h59C3);
      repeat (2) step();
      check("sb_leftover", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
